seq_code_detector: RTL and testbench

//  Parametrised button-sequence ("cheat code") detector. Tracks rising-edge presses
//  on NBTN debounced buttons while a switch key is set, and compares them against a
//  SEQ_LEN-entry code. Adds timeout, mismatch recovery, a sticky unlock and a hit counter.

---
 rtl/seq_code_detector_pkg.sv | 24 ++
 rtl/seq_code_detector_if.sv | 33 +++
 rtl/seq_code_detector_btn_edge_detect.sv | 28 ++
 rtl/seq_code_detector.sv | 145 ++++++++++++++
 tb/tb_seq_code_detector.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/seq_code_detector_pkg.sv
// rtl/seq_code_detector_pkg.sv - shared types and defaults for the button-sequence detector
//
// Purpose: FSM state encoding plus the default geometry and code that the
//          interface and top fall back on when not overridden.
// Ports:   none (package).

package seq_code_detector_pkg;

  typedef enum logic [1:0] {
    GATED = 2'd0,  // switch key wrong, nothing tracked
    ARMED = 2'd1,  // waiting for the first code entry
    TRACK = 2'd2   // part of the code matched
  } state_t;

  localparam int DEF_NBTN    = 4;
  localparam int DEF_SEQ_LEN = 8;
  localparam int DEF_SW_W    = 8;
  localparam int DEF_BW      = $clog2(DEF_NBTN);
  localparam int DEF_IDX_W   = $clog2(DEF_SEQ_LEN + 1);

  // U,U,D,D,L,R,L,R with U=0 D=1 L=2 R=3, entry 0 in the low bits
  localparam logic [DEF_SEQ_LEN*DEF_BW-1:0] DEF_CODE = 16'hEE50;

endpackage

// File: rtl/seq_code_detector_if.sv
// rtl/seq_code_detector_if.sv - control/status bundle between debouncers, detector and game logic
//
// Purpose: groups the switch key, button levels, clear and all detector outputs.
// Ports:   master drives sw/btn/clear and observes results; slave is the detector.

interface seq_code_detector_if
  import seq_code_detector_pkg::*;
#(
  parameter int NBTN   = DEF_NBTN,
  parameter int SW_W   = DEF_SW_W,
  parameter int PROG_W = DEF_IDX_W
);

  logic [SW_W-1:0]   sw;
  logic [NBTN-1:0]   btn;
  logic              clear;
  logic              match;
  logic              unlocked;
  logic [PROG_W-1:0] progress;
  logic [7:0]        hit_count;
  logic              timeout;

  modport master (
    output sw, btn, clear,
    input  match, unlocked, progress, hit_count, timeout
  );

  modport slave (
    input  sw, btn, clear,
    output match, unlocked, progress, hit_count, timeout
  );

endinterface

// File: rtl/seq_code_detector_btn_edge_detect.sv
// rtl/seq_code_detector_btn_edge_detect.sv - rising-edge press extraction for debounced buttons
//
// Purpose: registers the button levels and reports newly pressed buttons.
// Ports:   clk, reset (async, active-high), btn[W] levels in,
//          press[W] rising edges out, onehot = exactly one new press this cycle.

module seq_code_detector_btn_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press,
  output logic         onehot
);

  logic [W-1:0] btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_q <= '0;
    else       btn_q <= btn;
  end

  // a held button contributes only on the cycle it first rises
  assign press  = btn & ~btn_q;
  assign onehot = $onehot(press);

endmodule

// File: rtl/seq_code_detector.sv
// rtl/seq_code_detector.sv - gated button-sequence (cheat code) detector
//
// Purpose: while sw equals GATE_KEY, follows single button presses against CODE,
//          with idle timeout, restart-on-first-entry recovery, sticky unlock and
//          a saturating hit counter.
// Ports:   clk, reset (async, active-high), bus (slave): sw, btn, clear in;
//          match, unlocked, progress, hit_count, timeout out (all registered).

module seq_code_detector
  import seq_code_detector_pkg::*;
#(
  parameter int                                NBTN        = 4,
  parameter int                                SEQ_LEN     = 8,
  parameter int                                SW_W        = 8,
  parameter logic [SW_W-1:0]                   GATE_KEY    = 8'hAB,
  parameter logic [SEQ_LEN*$clog2(NBTN)-1:0]   CODE        = DEF_CODE,
  parameter int                                TIMEOUT_CYC = 50_000_000
) (
  input logic               clk,
  input logic               reset,
  seq_code_detector_if.slave bus
);

  localparam int BW    = $clog2(NBTN);
  localparam int IDX_W = $clog2(SEQ_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [NBTN-1:0]  press;
  logic             onehot;
  logic [BW-1:0]    press_idx;
  logic [BW-1:0]    want_code;
  logic             any_press;
  logic             good_press;
  logic             restart_press;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] idle;
  logic             match_q;
  logic             unlocked_q;
  logic [7:0]       hit_q;
  logic             timeout_q;

  seq_code_detector_btn_edge_detect #(.W(NBTN)) u_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (bus.btn),
    .press  (press),
    .onehot (onehot)
  );

  // binary index of the pressed button; only meaningful when onehot
  always_comb begin
    press_idx = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (press[i]) press_idx = BW'(i);
    end
  end

  assign want_code     = CODE[int'(idx)*BW +: BW];
  assign any_press     = |press;
  assign good_press    = onehot && (press_idx == want_code);
  assign restart_press = onehot && (press_idx == CODE[BW-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= GATED;
      idx        <= '0;
      idle       <= '0;
      match_q    <= 1'b0;
      unlocked_q <= 1'b0;
      hit_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (bus.clear) unlocked_q <= 1'b0;

      // closing the gate overrides any press or timeout in the same cycle
      if (bus.sw != GATE_KEY) begin
        state      <= GATED;
        idx        <= '0;
        idle       <= '0;
        unlocked_q <= 1'b0;
      end else begin
        case (state)
          GATED: begin
            state <= ARMED;
            idx   <= '0;
            idle  <= '0;
          end
          ARMED: begin
            idle <= '0;
            if (good_press) begin
              idx   <= IDX_W'(1);
              state <= TRACK;
            end
          end
          TRACK: begin
            if (any_press) begin
              idle <= '0;
              if (good_press) begin
                if (idx == IDX_W'(SEQ_LEN - 1)) begin
                  // placed after the clear above so a same-cycle clear loses
                  match_q    <= 1'b1;
                  unlocked_q <= 1'b1;
                  if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
                  idx        <= '0;
                  state      <= ARMED;
                end else begin
                  idx <= idx + IDX_W'(1);
                end
              end else if (restart_press) begin
                // a wrong press that is itself the first entry starts over at 1
                idx <= IDX_W'(1);
              end else begin
                idx   <= '0;
                state <= ARMED;
              end
            end else if (idle == CNT_W'(TIMEOUT_CYC - 1)) begin
              idle      <= '0;
              idx       <= '0;
              timeout_q <= 1'b1;
              state     <= ARMED;
            end else begin
              idle <= idle + CNT_W'(1);
            end
          end
          default: begin
            state <= GATED;
            idx   <= '0;
            idle  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.match     = match_q;
  assign bus.unlocked  = unlocked_q;
  assign bus.progress  = idx;
  assign bus.hit_count = hit_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_seq_code_detector.sv
// tb/tb_seq_code_detector.sv - self-checking bench for seq_code_detector

module tb_seq_code_detector;

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] U = 4'b0001;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] L = 4'b0100;
  localparam logic [3:0] R = 4'b1000;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  seq_code_detector_if bus ();

  seq_code_detector #(.TIMEOUT_CYC(100)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic       exp_unl = 1'b0;
  logic [7:0] exp_hit = 8'd0;
  logic [3:0] code_btn [8];

  task automatic expect_now(input string tag, input logic [3:0] p, input logic m, input logic t);
    exp_t e;
    e.tag = tag;
    e.val = {m, exp_unl, p, exp_hit, t};
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t        e;
    logic [14:0] obs;
    e   = sb.pop_front();
    obs = {bus.match, bus.unlocked, bus.progress, bus.hit_count, bus.timeout};
    checks++;
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed {m,u,prog,hit,to}=%h expected %h", e.tag, obs, e.val);
    end
  endtask

  // drive btn for one clock, then compare the registered outputs
  task automatic step(input logic [3:0] b, input string tag, input logic [3:0] p,
                      input logic m, input logic t);
    bus.btn = b;
    if (m) begin
      exp_unl = 1'b1;
      if (exp_hit != 8'd255) exp_hit = exp_hit + 8'd1;
    end
    expect_now(tag, p, m, t);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic press(input logic [3:0] b, input string tag, input logic [3:0] p,
                       input logic m, input int gap);
    step(b, tag, p, m, 1'b0);
    for (int i = 0; i < gap; i++) step(N, tag, p, 1'b0, 1'b0);
  endtask

  task automatic full_code(input string tag, input int gap);
    for (int i = 0; i < 8; i++)
      press(code_btn[i], tag, (i == 7) ? 4'd0 : 4'(i + 1), i == 7, gap);
  endtask

  initial begin
    code_btn  = '{U, U, D, D, L, R, L, R};
    reset     = 1'b1;
    bus.sw    = 8'hAB;
    bus.btn   = N;
    bus.clear = 1'b0;

    // reset state
    step(N, "reset0", 4'd0, 1'b0, 1'b0);
    step(N, "reset1", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(N, "arm", 4'd0, 1'b0, 1'b0);

    // 1: full code, presses 5 clocks apart
    full_code("t1_code", 4);

    // 2: wrong entries and restart-on-first-entry
    press(U, "t2_u1", 4'd1, 1'b0, 1);
    press(U, "t2_u2", 4'd2, 1'b0, 1);
    press(D, "t2_d3", 4'd3, 1'b0, 1);
    press(L, "t2_bad", 4'd0, 1'b0, 1);
    press(U, "t2_u1b", 4'd1, 1'b0, 1);
    press(U, "t2_u2b", 4'd2, 1'b0, 1);
    press(U, "t2_restart", 4'd1, 1'b0, 1);
    press(D, "t2_bad2", 4'd0, 1'b0, 1);

    // 3: timeout after 100 idle clocks; a press on the last idle clock wins
    press(U, "t3_u1", 4'd1, 1'b0, 1);
    press(U, "t3_u2", 4'd2, 1'b0, 0);
    for (int i = 0; i < 99; i++) step(N, "t3_idle", 4'd2, 1'b0, 1'b0);
    step(N, "t3_timeout", 4'd0, 1'b0, 1'b1);
    step(N, "t3_after", 4'd0, 1'b0, 1'b0);
    press(U, "t3b_u1", 4'd1, 1'b0, 1);
    press(U, "t3b_u2", 4'd2, 1'b0, 0);
    for (int i = 0; i < 99; i++) step(N, "t3b_idle", 4'd2, 1'b0, 1'b0);
    step(D, "t3b_late_press", 4'd3, 1'b0, 1'b0);
    step(N, "t3b_hold", 4'd3, 1'b0, 1'b0);
    step(R, "t3b_drop", 4'd0, 1'b0, 1'b0);
    step(N, "t3b_idle2", 4'd0, 1'b0, 1'b0);

    // 4: gate closed blocks tracking and drops unlock; gate drop beats a good press
    bus.sw  = 8'h00;
    exp_unl = 1'b0;
    step(N, "t4_gate", 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) press(code_btn[i], "t4_locked", 4'd0, 1'b0, 1);
    bus.sw = 8'hAB;
    step(N, "t4_arm", 4'd0, 1'b0, 1'b0);
    full_code("t4_code", 1);
    press(U, "t4_u1", 4'd1, 1'b0, 1);
    press(U, "t4_u2", 4'd2, 1'b0, 1);
    bus.sw  = 8'h00;
    exp_unl = 1'b0;
    step(D, "t4_drop", 4'd0, 1'b0, 1'b0);
    step(N, "t4_gated", 4'd0, 1'b0, 1'b0);
    bus.sw = 8'hAB;
    step(N, "t4_rearm", 4'd0, 1'b0, 1'b0);

    // 5: held button counts once; dual rise is a mismatch
    press(U, "t5_u1", 4'd1, 1'b0, 1);
    step(U, "t5_u2", 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) step(U, "t5_hold", 4'd2, 1'b0, 1'b0);
    step(U | D, "t5_d_while_u_held", 4'd3, 1'b0, 1'b0);
    step(N, "t5_release", 4'd3, 1'b0, 1'b0);
    step(U | D, "t5_dual", 4'd0, 1'b0, 1'b0);
    step(N, "t5_release2", 4'd0, 1'b0, 1'b0);
    step(U | D, "t5_dual_armed", 4'd0, 1'b0, 1'b0);
    step(N, "t5_release3", 4'd0, 1'b0, 1'b0);

    // 6: hit counter saturation, clear, clear vs match, reset mid-sequence
    for (int k = 0; k < 256; k++) full_code("t6_sat", 1);
    bus.clear = 1'b1;
    exp_unl   = 1'b0;
    step(N, "t6_clear", 4'd0, 1'b0, 1'b0);
    bus.clear = 1'b0;
    step(N, "t6_cleared", 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) press(code_btn[i], "t6_pre", 4'(i + 1), 1'b0, 1);
    bus.clear = 1'b1;
    exp_unl   = 1'b0;
    step(R, "t6_clear_vs_match", 4'd0, 1'b1, 1'b0);
    bus.clear = 1'b0;
    step(N, "t6_after_cm", 4'd0, 1'b0, 1'b0);
    press(U, "t6_r_u1", 4'd1, 1'b0, 1);
    press(U, "t6_r_u2", 4'd2, 1'b0, 1);
    press(D, "t6_r_d3", 4'd3, 1'b0, 0);
    #2;
    reset   = 1'b1;
    exp_unl = 1'b0;
    exp_hit = 8'd0;
    expect_now("t6_async_reset", 4'd0, 1'b0, 1'b0);
    #1;
    check_pop();
    step(D, "t6_in_reset", 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step(L, "t6_post_l", 4'd0, 1'b0, 1'b0);
    step(R, "t6_post_r", 4'd0, 1'b0, 1'b0);
    step(N, "t6_post_n", 4'd0, 1'b0, 1'b0);
    step(L, "t6_post_l2", 4'd0, 1'b0, 1'b0);
    step(R, "t6_post_r2", 4'd0, 1'b0, 1'b0);
    step(N, "t6_end", 4'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
